// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter.
// The optional round-robin mode is selected with the DMEM_ARB_RR_EN macro.
package dmem_arb_pkg;

  // Memory geometry the request struct is laid out for (2048 x 32-bit dmem)
  localparam int DMEM_ADDR_W  = 11;
  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_BYTES   = DMEM_DATA_W / 8;

  // Width of the DMA starvation counter (limit must fit, so 1..15)
  localparam int STARVE_CNT_W = 4;

  // Which requester owns the read data returning from dmem next cycle
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_DMA_RD = 2'd2
  } owner_t;

  // One memory access as presented on the dmem port
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [DMEM_BYTES-1:0]  be;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant decision for the dmem arbiter.
// Default: CPU has fixed priority, a starvation counter forces a DMA win
// after STARVE_LIMIT consecutive lost cycles.
// With DMEM_ARB_RR_EN defined: strict round-robin on a 1-bit last-winner flag.
// Grants are suppressed while i_reset is high.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_cpu_win,
  output logic o_dma_win
);

  logic dma_win;
  logic cpu_win;

`ifdef DMEM_ARB_RR_EN

  // 1 means the DMA port took the memory the last time anyone did.
  // Resets to 1 so the CPU wins the first contested cycle.
  logic last_dma_q;
  logic last_dma_d;

  // Contested cycles go to whichever port did not win last
  always_comb begin
    dma_win = 1'b0;
    cpu_win = 1'b0;
    if (!i_reset) begin
      dma_win = i_dma_req & (~i_cpu_req | ~last_dma_q);
      cpu_win = i_cpu_req & ~dma_win;
    end
  end

  // Remember the most recent winner; idle cycles keep the old value
  always_comb begin
    last_dma_d = last_dma_q;
    if (dma_win) begin
      last_dma_d = 1'b1;
    end else if (cpu_win) begin
      last_dma_d = 1'b0;
    end
  end

  // Last-winner register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_dma_q <= 1'b1;
    end else begin
      last_dma_q <= last_dma_d;
    end
  end

`else

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_d;
  logic                    force_dma;

  // CPU first, unless the DMA has been starved for LIMIT cycles in a row
  always_comb begin
    force_dma = (starve_cnt_q == LIMIT);
    dma_win   = 1'b0;
    cpu_win   = 1'b0;
    if (!i_reset) begin
      dma_win = i_dma_req & (~i_cpu_req | force_dma);
      cpu_win = i_cpu_req & ~dma_win;
    end
  end

  // Count consecutive cycles the DMA waited behind the CPU, saturating
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dma_win || !i_dma_req) begin
      starve_cnt_d = '0;
    end else if (cpu_win && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

`endif

  assign o_cpu_win = cpu_win;
  assign o_dma_win = dma_win;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port, 1-cycle-latency dmem.
// The CPU (MEM stage) and a debug/DMA loader share the memory; the winner's
// access is driven combinationally and read data is steered back to the
// owner one cycle later.
// Optional build macro: DMEM_ARB_RR_EN selects round-robin arbitration
// instead of CPU priority with starvation forcing.
//
// Handshake: a request is held stable by its source until accepted. The CPU
// access is accepted in any cycle where i_cpu_req is high and o_cpu_stall is
// low; the DMA access is accepted in any cycle where o_dma_gnt is high.
// Nothing is latched, so a request that is stalled or not granted must be
// re-presented unchanged. A read accepted in cycle t returns with a one-cycle
// rvalid pulse in cycle t+1; a reset in cycle t+1 drops that return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DMEM_ADDR_W,
  parameter int DATA_WIDTH   = DMEM_DATA_W,
  parameter int DATA_BYTES   = DATA_WIDTH / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  // CPU port
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  input  logic [DATA_BYTES-1:0] i_cpu_be,
  output logic                  o_cpu_stall,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  // DMA port
  input  logic                  i_dma_req,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  input  logic [DATA_BYTES-1:0] i_dma_be,
  output logic                  o_dma_gnt,
  output logic                  o_dma_rvalid,
  output logic [DATA_WIDTH-1:0] o_dma_rdata,
  // dmem port
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  output logic [DATA_BYTES-1:0] o_mem_be,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  // debug: current read-return owner
  output owner_t                o_dbg_owner
);

  logic     cpu_win;
  logic     dma_win;
  mem_req_t cpu_acc;
  mem_req_t dma_acc;
  mem_req_t mem_acc;

  owner_t                owner_q;
  owner_t                owner_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_d;
  logic                  cpu_rvalid;
  logic                  dma_rvalid;

  dmem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_cpu_req (i_cpu_req),
    .i_dma_req (i_dma_req),
    .o_cpu_win (cpu_win),
    .o_dma_win (dma_win)
  );

  // Stall and grant are pure functions of this cycle's decision; both are
  // forced low during reset
  always_comb begin
    o_dma_gnt   = dma_win;
    o_cpu_stall = ~i_reset & i_cpu_req & ~cpu_win;
  end

  // Pack both requests and pick the winner; with no winner present a
  // harmless no-op (no write, no byte enables) at the CPU address
  always_comb begin
    cpu_acc = '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata, be: i_cpu_be};
    dma_acc = '{we: i_dma_we, addr: i_dma_addr, wdata: i_dma_wdata, be: i_dma_be};
    mem_acc = '{we: 1'b0, addr: i_cpu_addr, wdata: i_cpu_wdata, be: '0};
    if (dma_win) begin
      mem_acc = dma_acc;
    end else if (cpu_win) begin
      mem_acc = cpu_acc;
    end
    o_mem_addr  = mem_acc.addr;
    o_mem_wdata = mem_acc.wdata;
    o_mem_we    = mem_acc.we;
    o_mem_be    = mem_acc.be;
  end

  // Next owner: only reads create one, CPU checked first (the two wins are
  // mutually exclusive anyway)
  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_win && !i_cpu_we) begin
      owner_d = OWN_CPU_RD;
    end else if (dma_win && !i_dma_we) begin
      owner_d = OWN_DMA_RD;
    end
  end

  // Read return: the owner recorded last cycle gets this cycle's dmem data.
  // Reset drops a return that is in flight.
  always_comb begin
    cpu_rvalid  = ~i_reset & (owner_q == OWN_CPU_RD);
    dma_rvalid  = ~i_reset & (owner_q == OWN_DMA_RD);
    cpu_rdata_d = cpu_rvalid ? i_mem_rdata : cpu_rdata_q;
    dma_rdata_d = dma_rvalid ? i_mem_rdata : dma_rdata_q;
  end

  // Owner FSM and held read-data registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_q     <= OWN_NONE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Data is passed straight through in the valid cycle and held afterwards
  always_comb begin
    o_cpu_rvalid = cpu_rvalid;
    o_dma_rvalid = dma_rvalid;
    o_cpu_rdata  = i_reset ? '0 : cpu_rdata_d;
    o_dma_rdata  = i_reset ? '0 : dma_rdata_d;
    o_dbg_owner  = owner_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by constrained
// random traffic, checked against a transaction-level model (arbitration by
// waiting-time rule, a shadow memory, and expected read-data queues).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int DEPTH = 2048;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic [BW-1:0] cpu_be, dma_be;
  logic          o_cpu_stall, o_cpu_rvalid, o_dma_gnt, o_dma_rvalid;
  logic [DW-1:0] o_cpu_rdata, o_dma_rdata;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic [BW-1:0] o_mem_be;
  logic [DW-1:0] mem_rdata;
  owner_t        dbg_owner;

  dmem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .DATA_BYTES   (BW),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_be     (cpu_be),
    .o_cpu_stall  (o_cpu_stall),
    .o_cpu_rvalid (o_cpu_rvalid),
    .o_cpu_rdata  (o_cpu_rdata),
    .i_dma_req    (dma_req),
    .i_dma_we     (dma_we),
    .i_dma_addr   (dma_addr),
    .i_dma_wdata  (dma_wdata),
    .i_dma_be     (dma_be),
    .o_dma_gnt    (o_dma_gnt),
    .o_dma_rvalid (o_dma_rvalid),
    .o_dma_rdata  (o_dma_rdata),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_we     (o_mem_we),
    .o_mem_be     (o_mem_be),
    .i_mem_rdata  (mem_rdata),
    .o_dbg_owner  (dbg_owner)
  );

  // dmem stand-in: write-first, byte-enabled, one cycle read latency
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    logic [DW-1:0] w;
    w = tb_mem[o_mem_addr];
    if (o_mem_we) begin
      for (int b = 0; b < BW; b++) if (o_mem_be[b]) w[8*b +: 8] = o_mem_wdata[8*b +: 8];
      tb_mem[o_mem_addr] = w;
    end
    mem_rdata <= w;
  end

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] cpu_exp_q [$];
  logic [DW-1:0] dma_exp_q [$];
  logic [DW-1:0] cpu_hold, dma_hold;
  int            m_wait;       // consecutive cycles DMA waited behind the CPU
  bit            m_last_dma;   // round-robin: DMA won most recently
  bit            m_cpu_win, m_dma_win;
  logic          obs_gnt, obs_stall, obs_we, obs_cpu_rvalid, obs_dma_rvalid;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    for (int b = 0; b < BW; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_reset();
    cpu_exp_q.delete();
    dma_exp_q.delete();
    cpu_hold   = '0;
    dma_hold   = '0;
    m_wait     = 0;
    m_last_dma = 1'b1;
  endtask

  // One clock: inputs already driven at the preceding negedge
  task automatic cycle();
    bit   exp_cpu_v, exp_dma_v;
    logic [DW-1:0] exp_cpu_d, exp_dma_d;
    owner_t exp_owner;
    #1;
    m_cpu_win = 1'b0;
    m_dma_win = 1'b0;
    if (!i_reset) begin
      if (cpu_req && dma_req) begin
`ifdef DMEM_ARB_RR_EN
        m_dma_win = !m_last_dma;
`else
        m_dma_win = (m_wait >= STARVE_LIMIT);
`endif
      end else begin
        m_dma_win = dma_req;
      end
      m_cpu_win = cpu_req && !m_dma_win;
    end
    obs_gnt        = o_dma_gnt;
    obs_stall      = o_cpu_stall;
    obs_we         = o_mem_we;
    obs_cpu_rvalid = o_cpu_rvalid;
    obs_dma_rvalid = o_dma_rvalid;

    check_eq("dma_gnt", o_dma_gnt, m_dma_win);
    check_eq("cpu_stall", o_cpu_stall, !i_reset && cpu_req && !m_cpu_win);
    if (m_dma_win) begin
      check_eq("mem_addr_dma", o_mem_addr, dma_addr);
      check_eq("mem_we_dma", o_mem_we, dma_we);
      check_eq("mem_be_dma", o_mem_be, dma_be);
      if (dma_we) check_eq("mem_wdata_dma", o_mem_wdata, dma_wdata);
    end else if (m_cpu_win) begin
      check_eq("mem_addr_cpu", o_mem_addr, cpu_addr);
      check_eq("mem_we_cpu", o_mem_we, cpu_we);
      check_eq("mem_be_cpu", o_mem_be, cpu_be);
      if (cpu_we) check_eq("mem_wdata_cpu", o_mem_wdata, cpu_wdata);
    end else begin
      check_eq("mem_we_idle", o_mem_we, 1'b0);
      check_eq("mem_be_idle", o_mem_be, '0);
      check_eq("mem_addr_idle", o_mem_addr, cpu_addr);
    end

    exp_cpu_v = !i_reset && (cpu_exp_q.size() > 0);
    exp_dma_v = !i_reset && (dma_exp_q.size() > 0);
    exp_cpu_d = i_reset ? '0 : (exp_cpu_v ? cpu_exp_q[0] : cpu_hold);
    exp_dma_d = i_reset ? '0 : (exp_dma_v ? dma_exp_q[0] : dma_hold);
    check_eq("cpu_rvalid", o_cpu_rvalid, exp_cpu_v);
    check_eq("dma_rvalid", o_dma_rvalid, exp_dma_v);
    check_eq("cpu_rdata", o_cpu_rdata, exp_cpu_d);
    check_eq("dma_rdata", o_dma_rdata, exp_dma_d);
    if (!i_reset) begin
      exp_owner = exp_cpu_v ? OWN_CPU_RD : (exp_dma_v ? OWN_DMA_RD : OWN_NONE);
      check_eq("owner", 32'(dbg_owner), 32'(exp_owner));
    end

    @(posedge clk);
    if (i_reset) begin
      model_reset();
    end else begin
      if (exp_cpu_v) cpu_hold = cpu_exp_q.pop_front();
      if (exp_dma_v) dma_hold = dma_exp_q.pop_front();
      if (m_cpu_win) begin
        if (cpu_we) ref_write(cpu_addr, cpu_wdata, cpu_be);
        else        cpu_exp_q.push_back(ref_mem[cpu_addr]);
      end
      if (m_dma_win) begin
        if (dma_we) ref_write(dma_addr, dma_wdata, dma_be);
        else        dma_exp_q.push_back(ref_mem[dma_addr]);
      end
      m_wait = (dma_req && m_cpu_win) ? m_wait + 1 : 0;
      if (m_dma_win)      m_last_dma = 1'b1;
      else if (m_cpu_win) m_last_dma = 1'b0;
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d; dma_be = be;
  endtask

  task automatic do_reset();
    drive_cpu(0, 0, '0, '0, '0);
    drive_dma(0, 0, '0, '0, '0);
    i_reset = 1'b1;
    cycle();
    cycle();
    i_reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic gnts [6];
    logic stalls [6];
    logic [DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    tb_mem[11'h010]  = 32'hDEADBEEF; ref_mem[11'h010] = 32'hDEADBEEF;
    tb_mem[11'h050]  = 32'hAAAAAAAA; ref_mem[11'h050] = 32'hAAAAAAAA;
    model_reset();
    i_reset = 1'b1;
    drive_cpu(0, 0, '0, '0, '0);
    drive_dma(0, 0, '0, '0, '0);
    @(negedge clk);
    do_reset();

    // CPU read alone
    drive_cpu(1, 0, 11'h010, '0, 4'hF);
    cycle();
    check_eq("p1_stall", obs_stall, 1'b0);
    drive_cpu(0, 0, 11'h010, '0, 4'hF);
    cycle();
    check_eq("p1_rvalid", obs_cpu_rvalid, 1'b1);
    check_eq("p1_dma_rvalid", obs_dma_rvalid, 1'b0);
    check_eq("p1_rdata", o_cpu_rdata, 32'hDEADBEEF);

    // Simultaneous CPU read and DMA write; CPU idles next cycle
    drive_cpu(1, 0, 11'h020, '0, 4'hF);
    drive_dma(1, 1, 11'h030, 32'h0BADF00D, 4'hF);
    cycle();
    check_eq("p2_c0_gnt", obs_gnt, 1'b0);
    check_eq("p2_c0_stall", obs_stall, 1'b0);
    drive_cpu(0, 0, 11'h020, '0, 4'hF);
    cycle();
    check_eq("p2_c1_gnt", obs_gnt, 1'b1);
    check_eq("p2_c1_we", obs_we, 1'b1);
    drive_dma(0, 0, '0, '0, '0);

    // CPU every cycle against a held DMA read: four CPU grants, then DMA
    drive_dma(1, 0, 11'h040, '0, 4'hF);
    for (int c = 0; c < 5; c++) begin
      drive_cpu(1, 0, AW'(11'h100 + c), '0, 4'hF);
      cycle();
      gnts[c]   = obs_gnt;
      stalls[c] = obs_stall;
    end
    drive_dma(0, 0, '0, '0, '0);
    cycle();  // CPU re-presents the stalled read
    gnts[5]   = obs_gnt;
    stalls[5] = obs_stall;
    check_eq("p3_dma_rvalid", obs_dma_rvalid, 1'b1);
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("p3_gnt%0d", c), gnts[c], (c == 4));
      check_eq($sformatf("p3_stall%0d", c), stalls[c], (c == 4));
    end
    drive_cpu(0, 0, '0, '0, '0);
    cycle();

    // DMA partial write then CPU read of the same word
    drive_dma(1, 1, 11'h050, 32'h11223344, 4'b0011);
    cycle();
    drive_dma(0, 0, '0, '0, '0);
    drive_cpu(1, 0, 11'h050, '0, 4'hF);
    cycle();
    drive_cpu(0, 0, '0, '0, '0);
    cycle();
    check_eq("p4_low_half", o_cpu_rdata[15:0], 16'h3344);
    check_eq("p4_word", o_cpu_rdata, 32'hAAAA3344);

    // Reset with a CPU read in flight
    drive_cpu(1, 0, 11'h060, '0, 4'hF);
    cycle();
    drive_cpu(0, 0, '0, '0, '0);
    i_reset = 1'b1;
    cycle();
    check_eq("p5_rst_rvalid", obs_cpu_rvalid, 1'b0);
    i_reset = 1'b0;
    cycle();
    check_eq("p5_post_rvalid", obs_cpu_rvalid, 1'b0);
    check_eq("p5_post_rdata", o_cpu_rdata, '0);

`ifdef DMEM_ARB_RR_EN
    // Both ports requesting continuously alternate, CPU first
    do_reset();
    drive_cpu(1, 0, 11'h070, '0, 4'hF);
    drive_dma(1, 0, 11'h071, '0, 4'hF);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check_eq($sformatf("rr_gnt%0d", c), obs_gnt, (c % 2 == 1));
    end
    drive_cpu(0, 0, '0, '0, '0);
    drive_dma(0, 0, '0, '0, '0);
    cycle();
`endif

    // Random traffic; a stalled or ungranted request is held unchanged
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!(cpu_req && !m_cpu_win)) begin
        drive_cpu(($urandom_range(0, 99) < 60), $urandom_range(0, 1), AW'($urandom_range(0, 15)),
                  $urandom, BW'($urandom_range(1, 15)));
      end
      if (!(dma_req && !m_dma_win)) begin
        drive_dma(($urandom_range(0, 99) < 50), $urandom_range(0, 1), AW'($urandom_range(0, 15)),
                  $urandom, BW'($urandom_range(1, 15)));
      end
      i_reset = ($urandom_range(0, 199) == 0);
      if (i_reset) begin
        drive_cpu(0, 0, '0, '0, '0);
        drive_dma(0, 0, '0, '0, '0);
      end
      cycle();
      check_eq("rvalid_excl", obs_cpu_rvalid & obs_dma_rvalid, 1'b0);
    end
    i_reset = 1'b0;
    drive_cpu(0, 0, '0, '0, '0);
    drive_dma(0, 0, '0, '0, '0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port, 1-cycle-latency data memory (dmem).
- Shares the memory between the pipeline MEM stage (CPU port) and a debug/DMA loader port (DMA port).
- CPU has fixed priority; a starvation counter guarantees DMA forward progress.
- Drives the memory port combinationally, routes read data back to the owner one cycle later, and stalls the CPU when it loses arbitration.

Parameters:
- ADDR_WIDTH, 11: word address width, matches dmem depth 2048.
- DATA_WIDTH, 32: data word width.
- DATA_BYTES, DATA_WIDTH/8: byte-enable width.
- STARVE_LIMIT, 4: consecutive lost cycles after which DMA is forced to win; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_cpu_req  in  1  CPU access request, MEM stage MemRead|MemWrite
- i_cpu_we  in  1  CPU write
- i_cpu_addr  in  ADDR_WIDTH  CPU word address
- i_cpu_wdata  in  DATA_WIDTH  CPU write data
- i_cpu_be  in  DATA_BYTES  CPU byte enables (mem_type)
- o_cpu_stall  out  1  CPU lost arbitration this cycle; freeze pipeline
- o_cpu_rvalid  out  1  CPU read data valid
- o_cpu_rdata  out  DATA_WIDTH  CPU read data
- i_dma_req  in  1  DMA access request
- i_dma_we  in  1  DMA write
- i_dma_addr  in  ADDR_WIDTH  DMA word address
- i_dma_wdata  in  DATA_WIDTH  DMA write data
- i_dma_be  in  DATA_BYTES  DMA byte enables
- o_dma_gnt  out  1  DMA request accepted this cycle
- o_dma_rvalid  out  1  DMA read data valid
- o_dma_rdata  out  DATA_WIDTH  DMA read data
- o_mem_addr  out  ADDR_WIDTH  to dmem i_addr
- o_mem_wdata  out  DATA_WIDTH  to dmem i_wdata
- o_mem_we  out  1  to dmem i_we
- o_mem_be  out  DATA_BYTES  to dmem i_mem_type
- i_mem_rdata  in  DATA_WIDTH  from dmem o_rdata; valid 1 cycle after access

Behaviour:
- Reset is synchronous and active-high on i_reset, clocked by i_clk.
- Reset values:
  - owner = OWN_NONE, starve_cnt = 0.
  - o_cpu_rvalid = 0, o_dma_rvalid = 0.
  - o_cpu_rdata = 0, o_dma_rdata = 0.
  - o_cpu_stall and o_dma_gnt follow the combinational rules below; they are 0 during reset.
- Grant logic (combinational):
  - force_dma = (starve_cnt == STARVE_LIMIT).
  - dma_win = i_dma_req & (~i_cpu_req | force_dma).
  - cpu_win = i_cpu_req & ~dma_win.
  - o_dma_gnt = dma_win.
  - o_cpu_stall = i_cpu_req & ~cpu_win.
- Memory mux:
  - Selects the winner's addr, wdata and be.
  - o_mem_we = winner's we.
  - No winner: o_mem_we = 0 and o_mem_be = 0, addr/wdata hold the CPU value (no-op access).
- Owner FSM (registered), states OWN_NONE, OWN_CPU_RD, OWN_DMA_RD:
  - Next state is OWN_CPU_RD if cpu_win & ~i_cpu_we.
  - Else OWN_DMA_RD if dma_win & ~i_dma_we.
  - Else OWN_NONE. Writes never create an owner.
- Read return (1-cycle latency):
  - In OWN_CPU_RD: o_cpu_rvalid = 1 and o_cpu_rdata = i_mem_rdata.
  - In OWN_DMA_RD: the same on the DMA side.
  - rvalid is a single-cycle pulse; the rdata register holds its last value until the next valid.
  - Both rvalids are never high together.
- Starvation counter (4 bits):
  - Increments, saturating at STARVE_LIMIT, when i_dma_req & cpu_win.
  - Clears on dma_win or ~i_dma_req.
- Boundary conditions:
  - Back-to-back CPU reads on consecutive cycles each produce their own rvalid.
  - A DMA write followed by a CPU read of the same address returns the new data (dmem is write-first).
  - Assertion of i_reset with a read in flight: the pending rvalid is dropped and the requester must reissue.
  - Requests must hold stable while stalled or not granted; the arbiter does not latch them.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: strict round-robin replaces CPU priority plus starvation counter.
  - A 1-bit last_winner register records the previous winner.
  - On simultaneous requests the port that did not win last is granted.
  - starve_cnt is removed.
- Undefined: CPU priority with STARVE_LIMIT forcing, as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - the owner_t enum (OWN_NONE, OWN_CPU_RD, OWN_DMA_RD);
  - the struct mem_req_t {we, addr, wdata, be};
  - a STARVE_CNT_W = 4 constant.
- One natural sub-module: dmem_arb_grant, holding the grant logic plus starve_cnt/last_winner. The top level does the muxing and the owner FSM.

Test Plan:
- CPU read only: addr 0x010, be 4'hF, memory word 0xDEADBEEF → no stall, o_cpu_rvalid=1 next cycle, o_cpu_rdata=0xDEADBEEF, o_dma_rvalid=0.
- Simultaneous CPU read 0x020 and DMA write 0x030 → cycle 0 CPU wins, o_dma_gnt=0, starve_cnt=1. CPU idles in cycle 1 → DMA granted, o_mem_we=1.
- CPU requests every cycle and DMA holds a read of 0x040 → exactly 4 CPU grants, then cycle 5 o_dma_gnt=1 and o_cpu_stall=1. DMA rvalid arrives in cycle 6 and starve_cnt=0.
- DMA writes 0x11223344 to 0x050 with be 4'b0011, then CPU reads 0x050 with be 4'hF → o_cpu_rdata lower half 0x3344.
- i_reset asserted in the cycle after a CPU read grant → o_cpu_rvalid stays 0, all outputs at reset values.
- With DMEM_ARB_RR_EN, both ports requesting continuously → grants alternate CPU, DMA, CPU, DMA starting with CPU after reset.
